// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux-select arbiter.
// Holds the FSM encoding, requester count and the index-to-one-hot helper.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OWN    = 2'd2
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr+1 (mod 4).
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner FSM driving the select lines of a 4:1 mux.
// A one-cycle SETTLE gap separates owners so the mux output is never ambiguous.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               S1,
  output logic               S0,
  output logic               sel_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               valid_q, valid_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] owner_oh;
  logic               owner_req;
  logic               others;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The select register doubles as the current winner/owner index.
  assign owner_oh  = onehot(sel_q);
  assign owner_req = req[sel_q];
  assign others    = |(req & ~owner_oh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        valid_d = 1'b0;
        if (pick_any) begin
          sel_d   = pick_idx;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (owner_req) begin
          state_d = OWN;
          grant_d = owner_oh;
          valid_d = 1'b1;
          ptr_d   = sel_q;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      OWN: begin
        // Leave on release, or when the hold budget is spent and someone waits.
        if (!owner_req || ((cnt_q == CNT_MAX) && others)) begin
          grant_d = '0;
          valid_d = 1'b0;
          if (others) begin
            sel_d   = pick_idx;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign grant     = grant_q;
  assign S1        = sel_q[1];
  assign S0        = sel_q[0];
  assign sel_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: HOLD_MAX=4 instance for the main sequence,
// HOLD_MAX=1 instance for single-cycle rotation under contention.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req0, req1;
  logic [3:0] grant0, grant1;
  logic       s1_0, s0_0, valid0;
  logic       s1_1, s0_1, valid1;
  logic [6:0] v0, v1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.HOLD_MAX(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req0),
    .grant     (grant0),
    .S1        (s1_0),
    .S0        (s0_0),
    .sel_valid (valid0)
  );

  mux_rr_arbiter #(.HOLD_MAX(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req       (req1),
    .grant     (grant1),
    .S1        (s1_1),
    .S0        (s0_1),
    .sel_valid (valid1)
  );

  // Observed vector: {grant[3:0], S1, S0, sel_valid}
  assign v0 = {grant0, s1_0, s0_0, valid0};
  assign v1 = {grant1, s1_1, s0_1, valid1};

  function automatic logic [6:0] exp_own(input logic [1:0] k);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    return {oh, k, 1'b1};
  endfunction

  function automatic logic [6:0] exp_gap(input logic [1:0] k);
    return {4'b0000, k, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed grant/S1S0/valid=%b required=%b", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req0 = 4'b0000;
    req1 = 4'b0000;
    #1;
    chk("reset_immediate", v0, 7'b0000_00_0);
    chk("reset_immediate_h1", v1, 7'b0000_00_0);
    tick();
    tick();
    rst = 1'b0;

    // Single requester A: two-cycle latency, then held ownership.
    req0 = 4'b0001;
    tick();
    chk("a_settle", v0, exp_gap(2'd0));
    tick();
    chk("a_own", v0, exp_own(2'd0));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("a_hold", v0, exp_own(2'd0));
    end

    // Full contention: A's budget is spent, rotation B,C,D,A with 4 OWN cycles each.
    req0 = 4'b1111;
    for (int r = 1; r <= 4; r++) begin
      tick();
      chk("rr_settle", v0, exp_gap(2'(r)));
      for (int c = 0; c < 4; c++) begin
        tick();
        chk("rr_own", v0, exp_own(2'(r)));
      end
    end

    // Hand C the mux, then C drops as A rises on the same edge.
    req0 = 4'b0100;
    tick();
    chk("c_settle", v0, exp_gap(2'd2));
    tick();
    chk("c_own", v0, exp_own(2'd2));
    req0 = 4'b0001;
    tick();
    chk("handoff_settle", v0, exp_gap(2'd0));
    tick();
    chk("handoff_own", v0, exp_own(2'd0));

    // Release to IDLE; select holds.
    req0 = 4'b0000;
    tick();
    chk("idle_after_release", v0, exp_gap(2'd0));

    // One-cycle pulse on C: SETTLE then IDLE, never granted.
    req0 = 4'b0100;
    tick();
    chk("pulse_settle", v0, exp_gap(2'd2));
    req0 = 4'b0000;
    tick();
    chk("pulse_idle", v0, exp_gap(2'd2));
    tick();
    chk("pulse_idle_hold", v0, exp_gap(2'd2));

    // ptr still A, so with A and C pending C is next in line.
    req0 = 4'b0101;
    tick();
    chk("ptr_kept_settle", v0, exp_gap(2'd2));
    tick();
    chk("ptr_kept_own", v0, exp_own(2'd2));

    // Move ownership to D, then reset mid-OWN.
    req0 = 4'b1000;
    tick();
    chk("d_settle", v0, exp_gap(2'd3));
    tick();
    chk("d_own", v0, exp_own(2'd3));
    rst = 1'b1;
    #1;
    chk("reset_mid_own", v0, 7'b0000_00_0);
    tick();
    chk("reset_held", v0, 7'b0000_00_0);
    rst  = 1'b0;
    req0 = 4'b1001;
    tick();
    chk("post_reset_settle", v0, exp_gap(2'd0));
    tick();
    chk("post_reset_own", v0, exp_own(2'd0));
    req0 = 4'b0000;

    // HOLD_MAX=1: A and B alternate one OWN cycle each.
    req1 = 4'b0011;
    tick();
    chk("h1_settle_a0", v1, exp_gap(2'd0));
    tick();
    chk("h1_own_a0", v1, exp_own(2'd0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h1_settle_b", v1, exp_gap(2'd1));
      tick();
      chk("h1_own_b", v1, exp_own(2'd1));
      tick();
      chk("h1_settle_a", v1, exp_gap(2'd0));
      tick();
      chk("h1_own_a", v1, exp_own(2'd0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
